// File: rtl/rtype_fetch_ctrl_pkg.sv
// Shared definitions for the R-type fetch/decode controller:
// opcode/funct constants, ALU_OP codes and the controller state type.
// Optional feature macro: RTYPE_ILLEGAL_TRAP_EN (illegal words halt the controller).
package rtype_fetch_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SLLV = 6'h04;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_t;

endpackage

// File: rtl/rtype_fetch_ctrl_decoder.sv
// Combinational R-type decoder: maps funct to ALU_OP and flags legal words.
// Non-R-type opcodes and unknown functs decode as illegal with ALU_OP=000.
module rtype_decoder
    import rtype_fetch_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic [2:0]  alu_op,
    output logic        legal
);

    // Register-field and shift-amount bits are not part of the decode.
    logic unused_fields;
    assign unused_fields = ^ir[25:6];

    // Funct lookup, qualified by the R-type opcode.
    always_comb begin
        alu_op = ALU_AND;
        legal  = 1'b0;
        if (ir[31:26] == OP_RTYPE) begin
            legal = 1'b1;
            case (ir[5:0])
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_SLTU: alu_op = ALU_SLTU;
                FN_SLLV: alu_op = ALU_SLLV;
                default: legal  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/rtype_fetch_ctrl.sv
// Multi-cycle fetch/decode controller for the register-file/ALU datapath.
// FETCH -> DECODE -> EXEC -> WB, one instruction retired every 4 cycles.
// Optional feature macro: RTYPE_ILLEGAL_TRAP_EN
//   defined   : an illegal word halts the controller (sticky Illegal)
//   undefined : an illegal word runs as a NOP, Illegal tied 0
module rtype_fetch_ctrl
    import rtype_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    output logic [ADDR_W-1:0] Inst_Addr,
    input  logic [31:0]       Inst_Data,
    output logic [4:0]        R_Addr_A,
    output logic [4:0]        R_Addr_B,
    output logic [4:0]        W_Addr,
    output logic [2:0]        ALU_OP,
    output logic              Write_Reg,
    output logic              Busy,
    output logic              Illegal,
    output logic [CNT_W-1:0]  Retired
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [2:0]        alu_op_q;
    logic              legal_q;
    logic              write_reg_q;
    logic              busy_q;
    logic [CNT_W-1:0]  retired_q;
    logic [2:0]        dec_alu_op;
    logic              dec_legal;

    // The decoder looks at the word arriving from the ROM so that the
    // legality decision can be made in DECODE, before IR is written.
    rtype_decoder u_decoder (
        .ir     (Inst_Data),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    // Opcode, shamt and funct are consumed from Inst_Data, not from IR.
    logic unused_ir;
    assign unused_ir = ^{ir[31:26], ir[10:0]};

`ifdef RTYPE_ILLEGAL_TRAP_EN
    logic illegal_q;
`endif

    // Controller FSM with PC, IR, retired counter and registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_FETCH;
            pc          <= '0;
            ir          <= '0;
            alu_op_q    <= ALU_AND;
            legal_q     <= 1'b0;
            write_reg_q <= 1'b0;
            busy_q      <= 1'b0;
            retired_q   <= '0;
`ifdef RTYPE_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    if (Run) begin
                        state  <= ST_DECODE;
                        busy_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    ir       <= Inst_Data;
                    alu_op_q <= dec_alu_op;
                    legal_q  <= dec_legal;
`ifdef RTYPE_ILLEGAL_TRAP_EN
                    if (!dec_legal) begin
                        state     <= ST_HALT;
                        busy_q    <= 1'b0;
                        illegal_q <= 1'b1;
                    end else begin
                        state <= ST_EXEC;
                    end
`else
                    state <= ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    state       <= ST_WB;
                    write_reg_q <= legal_q && (ir[15:11] != '0);
                end
                ST_WB: begin
                    state       <= ST_FETCH;
                    write_reg_q <= 1'b0;
                    busy_q      <= 1'b0;
                    pc          <= pc + 1'b1;
                    retired_q   <= retired_q + 1'b1;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state       <= ST_FETCH;
                    write_reg_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign Inst_Addr = pc;
    assign R_Addr_A  = ir[25:21];
    assign R_Addr_B  = ir[20:16];
    assign W_Addr    = ir[15:11];
    assign ALU_OP    = alu_op_q;
    assign Write_Reg = write_reg_q;
    assign Busy      = busy_q;
    assign Retired   = retired_q;
`ifdef RTYPE_ILLEGAL_TRAP_EN
    assign Illegal   = illegal_q;
`else
    assign Illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_rtype_fetch_ctrl.sv
// Self-checking bench for rtype_fetch_ctrl with a synchronous ROM model
// and an instruction-level reference model.
// Honours RTYPE_ILLEGAL_TRAP_EN the same way as the design.
module tb_rtype_fetch_ctrl;

    localparam int ADDR_W = 6;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Run;
    logic [ADDR_W-1:0] Inst_Addr;
    logic [31:0]       Inst_Data;
    logic [4:0]        R_Addr_A;
    logic [4:0]        R_Addr_B;
    logic [4:0]        W_Addr;
    logic [2:0]        ALU_OP;
    logic              Write_Reg;
    logic              Busy;
    logic              Illegal;
    logic [CNT_W-1:0]  Retired;

    rtype_fetch_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Run       (Run),
        .Inst_Addr (Inst_Addr),
        .Inst_Data (Inst_Data),
        .R_Addr_A  (R_Addr_A),
        .R_Addr_B  (R_Addr_B),
        .W_Addr    (W_Addr),
        .ALU_OP    (ALU_OP),
        .Write_Reg (Write_Reg),
        .Busy      (Busy),
        .Illegal   (Illegal),
        .Retired   (Retired)
    );

    always #5 Clk = ~Clk;

    // Synchronous instruction ROM: data appears the cycle after the address.
    logic [31:0] rom [DEPTH];
    always @(posedge Clk) Inst_Data <= rom[Inst_Addr];

    int checks = 0;
    int errors = 0;
    int unsigned m_pc  = 0;
    int unsigned m_ret = 0;

    // Funct codes in ALU_OP order: position in this table is the ALU_OP value.
    logic [5:0] functs [8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2B, 6'h04};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_decode(input logic [31:0] w, output logic legal, output logic [2:0] op);
        legal = 1'b0;
        op    = 3'd0;
        if (w[31:26] == 6'd0) begin
            for (int i = 0; i < 8; i++) begin
                if (w[5:0] == functs[i]) begin
                    legal = 1'b1;
                    op    = i[2:0];
                end
            end
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rd;
        op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
        fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : functs[$urandom_range(0, 7)];
        rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        w  = {op, 5'($urandom), 5'($urandom), rd, 5'($urandom), fn};
        return w;
    endfunction

    // Called at a negedge while the controller sits in FETCH.
    task automatic do_instr(input bit drop_run_in_exec);
        logic [31:0] w;
        logic        legal;
        logic [2:0]  op;
        w = rom[m_pc];
        ref_decode(w, legal, op);

        check("fetch_busy", {31'd0, Busy}, 32'd0);
        check("fetch_addr", {26'd0, Inst_Addr}, m_pc);
        check("fetch_wr", {31'd0, Write_Reg}, 32'd0);
        Run = 1'b1;

        @(negedge Clk);
        check("decode_busy", {31'd0, Busy}, 32'd1);
        check("decode_wr", {31'd0, Write_Reg}, 32'd0);

        @(negedge Clk);
`ifdef RTYPE_ILLEGAL_TRAP_EN
        if (!legal) begin
            for (int k = 0; k < 3; k++) begin
                check("halt_illegal", {31'd0, Illegal}, 32'd1);
                check("halt_busy", {31'd0, Busy}, 32'd0);
                check("halt_wr", {31'd0, Write_Reg}, 32'd0);
                check("halt_pc", {26'd0, Inst_Addr}, m_pc);
                check("halt_retired", {16'd0, Retired}, m_ret);
                @(negedge Clk);
            end
            rom[m_pc] = 32'h0022_1820;
            Reset = 1'b0;
            #1;
            check("halt_rst_illegal", {31'd0, Illegal}, 32'd0);
            @(negedge Clk);
            Reset = 1'b1;
            m_pc  = 0;
            m_ret = 0;
            return;
        end
`endif
        check("exec_busy", {31'd0, Busy}, 32'd1);
        check("exec_ra", {27'd0, R_Addr_A}, {27'd0, w[25:21]});
        check("exec_rb", {27'd0, R_Addr_B}, {27'd0, w[20:16]});
        check("exec_wa", {27'd0, W_Addr}, {27'd0, w[15:11]});
        check("exec_aluop", {29'd0, ALU_OP}, {29'd0, op});
        check("exec_wr", {31'd0, Write_Reg}, 32'd0);
        check("exec_illegal", {31'd0, Illegal}, 32'd0);
        if (drop_run_in_exec) Run = 1'b0;

        @(negedge Clk);
        check("wb_wr", {31'd0, Write_Reg}, {31'd0, (legal && (w[15:11] != 5'd0))});
        check("wb_busy", {31'd0, Busy}, 32'd1);
        check("wb_retired", {16'd0, Retired}, m_ret);
        check("wb_aluop", {29'd0, ALU_OP}, {29'd0, op});

        @(negedge Clk);
        m_pc  = (m_pc + 1) % DEPTH;
        m_ret = (m_ret + 1) % (1 << CNT_W);
        check("post_retired", {16'd0, Retired}, m_ret);
        check("post_wr", {31'd0, Write_Reg}, 32'd0);
        check("post_busy", {31'd0, Busy}, 32'd0);

        if (drop_run_in_exec) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge Clk);
                check("park_busy", {31'd0, Busy}, 32'd0);
                check("park_addr", {26'd0, Inst_Addr}, m_pc);
                check("park_wr", {31'd0, Write_Reg}, 32'd0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, {26'd0, Inst_Addr}, 32'd0);
        check({tag, "_wr"}, {31'd0, Write_Reg}, 32'd0);
        check({tag, "_retired"}, {16'd0, Retired}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_illegal"}, {31'd0, Illegal}, 32'd0);
        check({tag, "_aluop"}, {29'd0, ALU_OP}, 32'd0);
        check({tag, "_fields"}, {17'd0, R_Addr_A, R_Addr_B, W_Addr}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = rand_word();
        rom[0] = 32'h0022_1820;
        rom[1] = 32'h0043_0024;
        rom[2] = 32'h8C00_0000;

        Reset = 1'b0;
        Run   = 1'b1;
        #1;
        check_reset_values("rst0");
        repeat (2) @(negedge Clk);
        check_reset_values("rst1");
        Reset = 1'b1;
        m_pc  = 0;
        m_ret = 0;

        do_instr(1'b0);
        do_instr(1'b1);
        do_instr(1'b0);

        for (int n = 0; n < 75; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                Run = 1'b0;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                    @(negedge Clk);
                    check("idle_busy", {31'd0, Busy}, 32'd0);
                    check("idle_addr", {26'd0, Inst_Addr}, m_pc);
                end
            end
            do_instr($urandom_range(0, 9) == 0);
        end
        check("after_loop_retired", {16'd0, Retired}, m_ret);
        check("after_loop_pc", {26'd0, Inst_Addr}, m_pc);

        // Reset asserted in the middle of an instruction's EXEC cycle.
        rom[m_pc] = 32'h0022_1820;
        Run = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        check("mid_exec_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge Clk);
        check_reset_values("mid_rst_hold");
        Reset = 1'b1;
        m_pc  = 0;
        m_ret = 0;

        do_instr(1'b0);
        do_instr(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
